usb_reg_sequencer: RTL and testbench
====================================

Name: usb_reg_sequencer

Overview:
- Bus master that sits directly upstream of the USB host-chip bus slave (SL811-style, 8-bit, A0-indexed).
- Turns one register-burst command into the chip's two-phase protocol: one address byte (A0=0), then N data bytes (A0=1), relying on the chip's internal address auto-increment.
- Streams write bytes in and read bytes out through valid/ready interfaces.
- Serves the USB driver offload path: SIE register setup and packet-buffer fills and drains.

Parameters:
- MAX_LEN, 64, maximum bytes per burst; LEN_W = $clog2(MAX_LEN+1).
- TIMEOUT_CYCLES, 1024, per-access stall watchdog limit (only with the optional feature).

Ports:
- clk  in  1  bus clock, same domain as the slave's bus side.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_reg  in  8  starting chip register/buffer address.
- cmd_len  in  LEN_W  byte count, 1..MAX_LEN.
- wr_valid / wr_ready / wr_data  in / out / 8  write byte stream.
- rd_valid / rd_ready / rd_data  out / in / 8  read byte stream.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse with done on timeout or bad length.
- busy  out  1  high whenever not IDLE.
- bus_address  out  32  bit0 = A0, all other bits 0.
- bus_read / bus_write  out  1  downstream request strobes.
- bus_data_wr  out  32  byte in [7:0], upper bits 0.
- bus_data_rd  in  32  only [7:0] is used.
- bus_stall  in  1  slave busy flag.

Behaviour:
- Reset values: every output 0, except cmd_ready = 1. State = IDLE, counters = 0, rd output register empty.
- Downstream handshake, per access:
  - REQ: drive the strobe, address and data, and hold them.
  - Wait for bus_stall=1 (acceptance).
  - Then wait for bus_stall=0 (completion). Drop the strobe in that same cycle.
  - On a read, capture bus_data_rd[7:0] in that cycle.
  - A stall that is low before acceptance is ignored; this covers the slave's registered stall lag.
- One access is in flight at most. Strobes are never both high.
- IDLE:
  - Accept the command on cmd_valid & cmd_ready.
  - Latch reg, len and dir; remaining = cmd_len.
  - If cmd_len = 0 or cmd_len > MAX_LEN: pulse done + err next cycle and stay in IDLE.
- ADDR_REQ → ADDR_WAIT_ACC → ADDR_WAIT_DONE:
  - Write access with A0=0 and data = latched reg.
  - Then go to DATA_PREP.
- DATA_PREP:
  - Write: wr_ready=1. On wr_valid, latch the byte and go to DATA_REQ.
  - Read: go to DATA_REQ only when the rd output register is empty, or is being emptied this cycle.
- DATA_REQ → DATA_WAIT_ACC → DATA_WAIT_DONE:
  - Access with A0=1. On completion, decrement remaining.
  - On a read, load rd_data and set rd_valid.
  - If remaining becomes 0 go to DONE, else back to DATA_PREP.
- DONE: pulse done for one cycle, then return to IDLE.
- Read output register: 1 entry. rd_valid is held until rd_ready. rd_data stays stable while rd_valid & !rd_ready.
- Stalled consumer: no new read access is issued while the output register is full. The last byte may remain pending after done; a new read burst waits for it.
- Address wrap: the chip address auto-increments. A burst crossing 0xFF is not checked by this block; the driver is responsible.
- Reset mid-access: strobes drop immediately (asynchronous). The downstream slave recovers through its own reset.
- A command presented while busy is held off by cmd_ready=0.

Optional Feature:
- USB_SEQ_TIMEOUT_EN defined:
  - A counter runs in any WAIT state and clears on each new REQ.
  - When it reaches TIMEOUT_CYCLES: drop the strobe, pulse done + err, and go to IDLE.
  - Stale read data is discarded; the rd register is cleared.
- USB_SEQ_TIMEOUT_EN undefined:
  - No counter. WAIT states wait indefinitely.
  - err fires only for a bad length.

Decomposition:
- Shared package (common defs): UsbSeqState_t enum; USB_A0_ADDR = 1'b0 and USB_A0_DATA = 1'b1; the MAX_LEN default.
- One natural sub-module, usb_bus_access: a single-access REQ/ACC/DONE handshake engine, instantiated once and reused for both the address phase and the data phases.

Test Plan:
- Write reg 0x05, len 1, data 0xA5, with a slave model giving 3-cycle acceptance lag → bus sees (A0=0, 0x05) then (A0=1, 0xA5); exactly one done; err=0.
- Read reg 0x10, len 4, model returns 0x11, 0x22, 0x33, 0x44, rd_ready=1 → rd stream 0x11..0x44 in order; 5 downstream accesses total.
- Same read with rd_ready=0 for 20 cycles after the first byte → no further bus_read is issued; rd_data holds 0x11; burst completes after release.
- cmd_len=0, then cmd_len=MAX_LEN+1 → done + err pulses; no bus strobe is asserted.
- Write len 3 with wr_valid gaps of 5 cycles → bus_write is asserted only after each byte arrives; remaining counts 3→0.
- Timeout feature on, stall held high → after TIMEOUT_CYCLES: done + err, strobe low, IDLE. Also assert rst mid-access → all outputs at reset values immediately.

Source files
------------

// File: rtl/usb_reg_sequencer_pkg.sv
// Shared definitions for the SL811-style register burst sequencer.
package usb_reg_sequencer_pkg;

  localparam int unsigned USB_SEQ_MAX_LEN = 64;

  localparam logic USB_A0_ADDR = 1'b0;
  localparam logic USB_A0_DATA = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddrReq,
    StAddrWaitAcc,
    StAddrWaitDone,
    StDataPrep,
    StDataReq,
    StDataWaitAcc,
    StDataWaitDone,
    StDone
  } UsbSeqState_t;

endpackage

// File: rtl/usb_bus_access.sv
// Single downstream access engine: raise strobe, wait for stall high (accepted),
// then stall low (completed). Shared by the address phase and every data phase.
module usb_bus_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        write,
  input  logic        a0,
  input  logic [7:0]  wdata,
  input  logic        bus_stall,
  output logic        accepted,
  output logic        complete,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_wr
);

  typedef enum logic [1:0] {AccIdle, AccWaitAcc, AccWaitDone} acc_state_t;

  acc_state_t state;

  // A low stall before acceptance is the slave's registered lag, not completion.
  assign accepted = (state == AccWaitAcc) && bus_stall;
  assign complete = (state == AccWaitDone) && !bus_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= AccIdle;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      bus_address <= '0;
      bus_data_wr <= '0;
    end else if (abort) begin
      state     <= AccIdle;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
    end else begin
      unique case (state)
        AccIdle: begin
          if (start) begin
            bus_read    <= !write;
            bus_write   <= write;
            bus_address <= {31'b0, a0};
            bus_data_wr <= write ? {24'b0, wdata} : 32'b0;
            state       <= AccWaitAcc;
          end
        end
        AccWaitAcc: begin
          if (bus_stall) state <= AccWaitDone;
        end
        AccWaitDone: begin
          if (!bus_stall) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= AccIdle;
          end
        end
        default: state <= AccIdle;
      endcase
    end
  end

endmodule

// File: rtl/usb_reg_sequencer.sv
// Register burst master for an SL811-style host chip: one A0=0 address write, then
// N A0=1 data accesses. Optional per-access watchdog: define USB_SEQ_TIMEOUT_EN.
module usb_reg_sequencer
  import usb_reg_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN = USB_SEQ_MAX_LEN,
`ifdef USB_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024,
`endif
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [31:0]      bus_address,
  output logic             bus_read,
  output logic             bus_write,
  output logic [31:0]      bus_data_wr,
  input  logic [31:0]      bus_data_rd,
  input  logic             bus_stall
);

  localparam logic [LEN_W-1:0] MaxLenV = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] OneV    = LEN_W'(1);

  UsbSeqState_t     state;
  logic [7:0]       reg_q;
  logic             dir_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       byte_q;

  logic       acc_start, acc_write, acc_a0, accepted, complete, timeout;
  logic [7:0] acc_wdata;
  logic       unused_rd_hi;

  assign unused_rd_hi = ^bus_data_rd[31:8];

  assign cmd_ready = (state == StIdle);
  assign busy      = !cmd_ready;
  assign wr_ready  = (state == StDataPrep) && dir_q;

  assign acc_start = (state == StAddrReq) || (state == StDataReq);
  assign acc_write = (state == StAddrReq) ? 1'b1 : dir_q;
  assign acc_a0    = (state == StAddrReq) ? USB_A0_ADDR : USB_A0_DATA;
  assign acc_wdata = (state == StAddrReq) ? reg_q : byte_q;

`ifdef USB_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = (state == StAddrWaitAcc) || (state == StAddrWaitDone) ||
                   (state == StDataWaitAcc) || (state == StDataWaitDone);
  assign timeout = waiting && (to_cnt == ToLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (acc_start) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  usb_bus_access u_access (
    .clk         (clk),
    .rst         (rst),
    .start       (acc_start),
    .abort       (timeout),
    .write       (acc_write),
    .a0          (acc_a0),
    .wdata       (acc_wdata),
    .bus_stall   (bus_stall),
    .accepted    (accepted),
    .complete    (complete),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_address (bus_address),
    .bus_data_wr (bus_data_wr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      reg_q    <= '0;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      byte_q   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (timeout) begin
        state    <= StIdle;
        done     <= 1'b1;
        err      <= 1'b1;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (cmd_valid) begin
              reg_q <= cmd_reg;
              dir_q <= cmd_write;
              rem_q <= cmd_len;
              if (cmd_len == '0 || cmd_len > MaxLenV) begin
                done <= 1'b1;
                err  <= 1'b1;
              end else begin
                state <= StAddrReq;
              end
            end
          end
          StAddrReq:      state <= StAddrWaitAcc;
          StAddrWaitAcc:  if (accepted) state <= StAddrWaitDone;
          StAddrWaitDone: if (complete) state <= StDataPrep;
          StDataPrep: begin
            if (dir_q) begin
              if (wr_valid) begin
                byte_q <= wr_data;
                state  <= StDataReq;
              end
            end else if (!rd_valid || rd_ready) begin
              // The single output slot must be free before the next read is issued.
              state <= StDataReq;
            end
          end
          StDataReq:     state <= StDataWaitAcc;
          StDataWaitAcc: if (accepted) state <= StDataWaitDone;
          StDataWaitDone: begin
            if (complete) begin
              rem_q <= rem_q - OneV;
              if (!dir_q) begin
                rd_valid <= 1'b1;
                rd_data  <= bus_data_rd[7:0];
              end
              if (rem_q == OneV) begin
                state <= StDone;
                done  <= 1'b1;
              end else begin
                state <= StDataPrep;
              end
            end
          end
          StDone:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_reg_sequencer.sv
// Randomized bench: a behavioural chip slave with auto-increment pointer, and a
// burst-level model predicting the access sequence and the read byte stream.
module tb_usb_reg_sequencer;
  import usb_reg_sequencer_pkg::*;

  localparam int MAXL = USB_SEQ_MAX_LEN;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_reg;
  logic [6:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        done, err, busy;
  logic [31:0] bus_address, bus_data_wr, bus_data_rd;
  logic        bus_read, bus_write, bus_stall;

  usb_reg_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .busy(busy), .bus_address(bus_address),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_wr(bus_data_wr),
    .bus_data_rd(bus_data_rd), .bus_stall(bus_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] ref_mem[256];
  logic [7:0] slave_mem[256];
  logic [7:0] wbytes[MAXL];
  logic [9:0] obs_q[$];
  logic [9:0] exp_acc[$];
  logic [7:0] rd_got[$];
  logic [7:0] exp_rd[$];

  int lag_lo = 0, lag_hi = 3;
  bit stuck = 0;
  bit rd_hold = 0;
  int done_cnt = 0, err_cnt = 0, strobe_viol = 0, hold_viol = 0;
  int d0, e0;

  // Chip slave: {a0, write, data} recorded per completed access.
  initial begin
    int phase, lag, hold;
    logic [9:0] cur;
    logic [7:0] ptr;
    phase = 0; ptr = 0; cur = 0; lag = 0; hold = 0;
    bus_stall = 1'b0;
    bus_data_rd = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        phase = 0;
        bus_stall = 1'b0;
      end else begin
        case (phase)
          0: if (bus_read || bus_write) begin
            cur = {bus_address[0], bus_write, bus_write ? bus_data_wr[7:0] : 8'h00};
            lag = $urandom_range(lag_hi, lag_lo);
            phase = 1;
          end
          1: if (lag == 0) begin
            bus_stall = 1'b1;
            hold = $urandom_range(2, 0);
            phase = 2;
          end else lag--;
          2: if (!stuck) begin
            if (hold == 0) begin
              if (!cur[9]) ptr = cur[7:0];
              else if (cur[8]) begin slave_mem[ptr] = cur[7:0]; ptr++; end
              else begin bus_data_rd = {24'hABCDEF, slave_mem[ptr]}; ptr++; end
              bus_stall = 1'b0;
              obs_q.push_back(cur);
              phase = 3;
            end else hold--;
          end
          default: if (!bus_read && !bus_write) phase = 0;
        endcase
      end
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_ready = rd_hold ? 1'b0 : ($urandom_range(3, 0) != 0);
    end
  end

  // Monitor on the falling edge, away from the active edge.
  initial begin
    bit hold_prev;
    logic [7:0] hold_data;
    hold_prev = 0; hold_data = 0;
    forever begin
      @(negedge clk);
      if (rst) hold_prev = 0;
      else begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (bus_read && bus_write) strobe_viol++;
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        if (hold_prev && (!rd_valid || rd_data != hold_data)) hold_viol++;
        hold_prev = rd_valid && !rd_ready;
        hold_data = rd_data;
      end
    end
  end

  task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    slave_mem[a] = v;
  endtask

  task automatic issue_cmd(input bit wr, input logic [7:0] rg, input int len, input int gap_max);
    int n;
    logic [7:0] a;
    d0 = done_cnt;
    e0 = err_cnt;
    if (len >= 1 && len <= MAXL) begin
      exp_acc.push_back({USB_A0_ADDR, 1'b1, rg});
      for (int i = 0; i < len; i++) begin
        a = rg + 8'(i);
        if (wr) begin
          exp_acc.push_back({USB_A0_DATA, 1'b1, wbytes[i]});
          ref_mem[a] = wbytes[i];
        end else begin
          exp_acc.push_back({USB_A0_DATA, 1'b0, 8'h00});
          exp_rd.push_back(ref_mem[a]);
        end
      end
    end
    cmd_write = wr; cmd_reg = rg; cmd_len = 7'(len); cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) check("cmd_ready_wait", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (wr && len >= 1 && len <= MAXL) begin
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
        wr_valid = 1'b1;
        wr_data = wbytes[i];
        n = 0;
        while (!wr_ready && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) check("wr_ready_wait", 0, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
      end
    end
  endtask

  task automatic finish_cmd(input bit exp_err);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", done_cnt - d0, 1);
    check("err_count", err_cnt - e0, 32'(exp_err));
    check("acc_count", obs_q.size(), exp_acc.size());
    for (int i = 0; i < obs_q.size() && i < exp_acc.size(); i++)
      check($sformatf("acc[%0d]", i), 32'(obs_q[i]), 32'(exp_acc[i]));
    obs_q.delete();
    exp_acc.delete();
  endtask

  task automatic drain_rd();
    int n;
    rd_hold = 0;
    n = 0;
    while (rd_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("rd_stream_len", rd_got.size(), exp_rd.size());
    for (int i = 0; i < rd_got.size() && i < exp_rd.size(); i++)
      check($sformatf("rd[%0d]", i), 32'(rd_got[i]), 32'(exp_rd[i]));
    rd_got.delete();
    exp_rd.delete();
  endtask

  task automatic raw_cmd(input bit wr, input logic [7:0] rg, input logic [6:0] len);
    d0 = done_cnt;
    e0 = err_cnt;
    cmd_write = wr; cmd_reg = rg; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, len;
    bit wr, is_bad;
    cmd_valid = 0; cmd_write = 0; cmd_reg = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0;
    for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_strobes", {bus_read, bus_write}, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_bus_address", bus_address, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write with a three-cycle acceptance lag.
    lag_lo = 3; lag_hi = 3;
    wbytes[0] = 8'hA5;
    issue_cmd(1, 8'h05, 1, 0);
    finish_cmd(0);
    lag_lo = 0;

    // Four-byte read, consumer always ready.
    set_mem(8'h10, 8'h11); set_mem(8'h11, 8'h22); set_mem(8'h12, 8'h33); set_mem(8'h13, 8'h44);
    issue_cmd(0, 8'h10, 4, 0);
    finish_cmd(0);
    drain_rd();

    // Same read with the consumer stalled after the first byte.
    rd_hold = 1;
    issue_cmd(0, 8'h10, 4, 0);
    n = 0;
    while (!rd_valid && n < 500) begin @(posedge clk); #1; n++; end
    repeat (20) begin @(posedge clk); #1; end
    check("stall_acc_count", obs_q.size(), 2);
    check("stall_rd_data", rd_data, 8'h11);
    check("stall_no_read", bus_read, 0);
    rd_hold = 0;
    finish_cmd(0);
    drain_rd();

    // Illegal lengths: done+err, no bus traffic.
    issue_cmd(1, 8'h33, 0, 0);
    finish_cmd(1);
    issue_cmd(0, 8'h33, MAXL + 1, 0);
    finish_cmd(1);

    // Write with producer gaps, and a full-length burst.
    for (int i = 0; i < 3; i++) wbytes[i] = 8'($urandom);
    issue_cmd(1, 8'h40, 3, 5);
    finish_cmd(0);
    for (int i = 0; i < MAXL; i++) wbytes[i] = 8'($urandom);
    issue_cmd(1, 8'hE0, MAXL, 1);
    finish_cmd(0);
    issue_cmd(0, 8'hE0, MAXL, 0);
    finish_cmd(0);
    drain_rd();

    // Randomized mix; read bytes may still be pending when the next burst starts.
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(1, 0));
      is_bad = ($urandom_range(9, 0) == 0);
      len = is_bad ? (($urandom_range(1, 0) == 0) ? 0 : $urandom_range(127, MAXL + 1))
                   : $urandom_range(6, 1);
      lag_hi = $urandom_range(4, 0);
      for (int i = 0; i < MAXL; i++) wbytes[i] = 8'($urandom);
      issue_cmd(wr, 8'($urandom), len, 3);
      finish_cmd(is_bad);
    end
    drain_rd();
    lag_hi = 3;

`ifdef USB_SEQ_TIMEOUT_EN
    stuck = 1;
    raw_cmd(1, 8'h20, 7'd1);
    n = 0;
    while (done_cnt == d0 && n < 1500) begin @(posedge clk); #1; n++; end
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_strobe", {bus_read, bus_write}, 0);
    check("timeout_idle", cmd_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stuck = 0;
    obs_q.delete();
    @(posedge clk); #1;
`endif

    // Reset in the middle of an access.
    stuck = 1;
    raw_cmd(1, 8'h21, 7'd2);
    n = 0;
    while (!bus_write && n < 100) begin @(posedge clk); #1; n++; end
    check("pre_rst_strobe", bus_write, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", {bus_read, bus_write}, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bus_address", bus_address, 0);
    check("mid_rst_bus_data_wr", bus_data_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stuck = 0;
    obs_q.delete();
    @(posedge clk); #1;
    wbytes[0] = 8'h5A;
    issue_cmd(1, 8'h22, 1, 0);
    finish_cmd(0);

    check("strobe_overlap", strobe_viol, 0);
    check("rd_hold_stable", hold_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
